permute_scheduler: RTL and testbench

Round sequencer and memory-port arbiter for the Permute engine. It owns the 25-bit port of Memory and grants it either to a host (state load/unload) or to Permute. It issues one Permute start per round for ROUNDS rounds and reports completion, with a per-round watchdog. It sits between the top-level controller, Permute and Memory.

---
 rtl/permute_pkg.sv | 16 +
 rtl/permute_scheduler_if.sv | 13 +
 rtl/mem_port_mux.sv | 29 ++
 rtl/permute_scheduler.sv | 122 ++++++++++++
 tb/tb_permute_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/permute_pkg.sv
// Shared types and widths for the Permute round scheduler and its memory port mux.
package permute_pkg;

  localparam int ADR_W  = 6;
  localparam int LANE_W = 25;
  localparam int RND_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOST   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/permute_scheduler_if.sv
// One 25-bit Memory port: address, write data, read and write strobes.
interface permute_scheduler_if;
  import permute_pkg::*;

  logic [ADR_W-1:0]  adr;
  logic [LANE_W-1:0] din;
  logic              r;
  logic              w;

  modport master (output adr, din, r, w);
  modport slave  (input  adr, din, r, w);

endinterface

// File: rtl/mem_port_mux.sv
// Combinational owner select for the Memory port; drives zeros when nobody owns it.
module mem_port_mux (
  input  logic                   sel_host,
  input  logic                   sel_perm,
  permute_scheduler_if.slave     host,
  permute_scheduler_if.slave     perm,
  permute_scheduler_if.master    mem
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem.adr = '0;
    mem.din = '0;
    mem.r   = 1'b0;
    mem.w   = 1'b0;
    if (sel_host) begin
      mem.adr = host.adr;
      mem.din = host.din;
      mem.r   = host.r;
      mem.w   = host.w;
    end else if (sel_perm) begin
      mem.adr = perm.adr;
      mem.din = perm.din;
      mem.r   = perm.r;
      mem.w   = perm.w;
    end
  end

endmodule

// File: rtl/permute_scheduler.sv
// Round sequencer for Permute with per-round watchdog; arbitrates the Memory port
// between the host (load/unload) and Permute.
module permute_scheduler
  import permute_pkg::*;
#(
  parameter int unsigned ROUNDS  = 24,
  parameter int unsigned TIMEOUT = 1024,
  parameter bit          MODE    = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  output logic                busy,
  output logic                finished,
  output logic                err,
  output logic [RND_W-1:0]    round,
  input  logic                host_req,
  output logic                host_gnt,
  output logic                perm_start,
  input  logic                perm_done,
  permute_scheduler_if.slave  host,
  permute_scheduler_if.slave  perm,
  permute_scheduler_if.master mem,
  output logic                mode
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            done_q;

  // A zero watchdog marks the first RUN cycle, where a done left over from the
  // previous round must not count.
  assign done_q = perm_done && (wd != '0);

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      round      <= '0;
      err        <= 1'b0;
      wd         <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      host_gnt   <= 1'b0;
      perm_start <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      finished   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_START;
            err        <= 1'b0;
            round      <= '0;
            busy       <= 1'b1;
            perm_start <= 1'b1;
          end else if (host_req) begin
            state    <= S_HOST;
            host_gnt <= 1'b1;
          end
        end
        S_HOST: begin
          if (!host_req) begin
            state    <= S_IDLE;
            host_gnt <= 1'b0;
          end
        end
        S_START: begin
          state <= S_RUN;
          wd    <= '0;
        end
        S_RUN: begin
          // Done is checked before the watchdog so it wins a same-edge tie.
          if (done_q) begin
            wd <= '0;
            if (round == RND_LAST) begin
              state    <= S_FINISH;
              finished <= 1'b1;
            end else begin
              state      <= S_START;
              round      <= round + 1'b1;
              perm_start <= 1'b1;
            end
          end else if (wd == WD_LAST) begin
            state <= S_IDLE;
            err   <= 1'b1;
            round <= '0;
            busy  <= 1'b0;
            wd    <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          round <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          host_gnt <= 1'b0;
        end
      endcase
    end
  end

  mem_port_mux u_mux (
    .sel_host (state == S_HOST),
    .sel_perm ((state == S_START) || (state == S_RUN)),
    .host     (host),
    .perm     (perm),
    .mem      (mem)
  );

  assign mode = MODE;

endmodule

// File: tb/tb_permute_scheduler.sv
// Scoreboard bench for permute_scheduler with ROUNDS=3, TIMEOUT=8 and a Permute
// model that answers each start with done four cycles later.
module tb_permute_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        host_req = 1'b0;
  logic        perm_done = 1'b0;
  logic        busy, finished, err, host_gnt, perm_start, mode;
  logic [4:0]  round;

  permute_scheduler_if host_bus ();
  permute_scheduler_if perm_bus ();
  permute_scheduler_if mem_bus ();

  permute_scheduler #(.ROUNDS(3), .TIMEOUT(8), .MODE(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .busy       (busy),
    .finished   (finished),
    .err        (err),
    .round      (round),
    .host_req   (host_req),
    .host_gnt   (host_gnt),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .host       (host_bus),
    .perm       (perm_bus),
    .mem        (mem_bus),
    .mode       (mode)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  bit model_en = 1'b0;
  bit armed = 1'b0;
  int mcnt = 0;

  // Permute model: done is high in the fourth cycle after the start cycle.
  always @(posedge clock) begin
    #1;
    if (model_en) begin
      if (perm_start) begin
        armed = 1'b1;
        mcnt = 4;
        perm_done = 1'b0;
      end else if (armed) begin
        mcnt--;
        if (mcnt == 0) begin
          perm_done = 1'b1;
          armed = 1'b0;
        end else begin
          perm_done = 1'b0;
        end
      end else begin
        perm_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    host_bus.adr = 6'd9;  host_bus.din = 25'h155;  host_bus.r = 1'b1; host_bus.w = 1'b1;
    perm_bus.adr = 6'd12; perm_bus.din = 25'h0AA;  perm_bus.r = 1'b1; perm_bus.w = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (mem_bus.w !== 1'b0) begin miscompares++; $display("FAIL reset_mem_w_held got=%b exp=0", mem_bus.w); end
    @(negedge clock) reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b exp=0", busy); end
    vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL idle_finished got=%b exp=0", finished); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL idle_err got=%b exp=0", err); end
    vectors++; if (round !== 5'd0) begin miscompares++; $display("FAIL idle_round got=%0d exp=0", round); end
    vectors++; if (host_gnt !== 1'b0) begin miscompares++; $display("FAIL idle_host_gnt got=%b exp=0", host_gnt); end
    vectors++; if (perm_start !== 1'b0) begin miscompares++; $display("FAIL idle_perm_start got=%b exp=0", perm_start); end
    vectors++; if (mem_bus.w !== 1'b0) begin miscompares++; $display("FAIL idle_mem_w got=%b exp=0", mem_bus.w); end
    vectors++; if (mem_bus.r !== 1'b0) begin miscompares++; $display("FAIL idle_mem_r got=%b exp=0", mem_bus.r); end
    vectors++; if (mem_bus.adr !== 6'd0) begin miscompares++; $display("FAIL idle_mem_adr got=%0d exp=0", mem_bus.adr); end
    vectors++; if (mem_bus.din !== 25'd0) begin miscompares++; $display("FAIL idle_mem_in got=%h exp=0", mem_bus.din); end
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL idle_mode got=%b exp=1", mode); end
    host_bus.r = 1'b0; host_bus.w = 1'b0;
    perm_bus.r = 1'b0; perm_bus.w = 1'b0;
  endtask

  task automatic test_full_run();
    int n, starts, fins, fin_at;
    logic [4:0] e;
    model_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(5'(i));
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 1; starts = 0; fins = 0; fin_at = 0;
    while (n <= 30) begin
      if (perm_start) begin
        starts++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL run_extra_start got_round=%0d exp=none", round);
        end else begin
          e = exp_q.pop_front();
          if (round !== e) begin miscompares++; $display("FAIL run_round got=%0d exp=%0d", round, e); end
        end
      end
      if (finished) begin
        fins++;
        if (fin_at == 0) fin_at = n;
      end
      tick();
      n++;
    end
    vectors++; if (starts != 3) begin miscompares++; $display("FAIL run_starts got=%0d exp=3", starts); end
    vectors++; if (fins != 1) begin miscompares++; $display("FAIL run_finished_pulses got=%0d exp=1", fins); end
    vectors++; if (fin_at != 16) begin miscompares++; $display("FAIL run_latency got=%0d exp=16", fin_at); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL run_err got=%b exp=0", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL run_busy_after got=%b exp=0", busy); end
    vectors++; if (round !== 5'd0) begin miscompares++; $display("FAIL run_round_after got=%0d exp=0", round); end
  endtask

  task automatic test_arbitration();
    int n;
    logic [4:0] e;
    model_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(5'(i));
    perm_bus.adr = 6'd7; perm_bus.r = 1'b1; perm_bus.w = 1'b0; perm_bus.din = 25'h0F0F;
    host_bus.adr = 6'd5; host_bus.w = 1'b1; host_bus.r = 1'b0; host_bus.din = 25'h1ABCDE;
    go = 1'b1; host_req = 1'b1;
    tick();
    go = 1'b0;
    vectors++; if (perm_start !== 1'b1) begin miscompares++; $display("FAIL arb_go_priority got=%b exp=1", perm_start); end
    n = 0;
    while (!finished && n < 40) begin
      if (perm_start) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL arb_extra_start got_round=%0d exp=none", round);
        end else begin
          e = exp_q.pop_front();
          if (round !== e) begin miscompares++; $display("FAIL arb_round got=%0d exp=%0d", round, e); end
        end
      end
      vectors++; if (host_gnt !== 1'b0) begin miscompares++; $display("FAIL arb_gnt_in_run got=%b exp=0", host_gnt); end
      vectors++;
      if (mem_bus.adr !== 6'd7 || mem_bus.w !== 1'b0 || mem_bus.r !== 1'b1) begin
        miscompares++; $display("FAIL arb_perm_owner adr=%0d w=%b r=%b exp adr=7 w=0 r=1", mem_bus.adr, mem_bus.w, mem_bus.r);
      end
      tick();
      n++;
    end
    vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL arb_finish_timeout got=%b exp=1", finished); end
    vectors++; if (mem_bus.r !== 1'b0) begin miscompares++; $display("FAIL arb_finish_mem_r got=%b exp=0", mem_bus.r); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL arb_missing_starts got=%0d exp=0", exp_q.size()); end
    tick();
    vectors++; if (host_gnt !== 1'b0) begin miscompares++; $display("FAIL arb_gnt_idle got=%b exp=0", host_gnt); end
    tick();
    vectors++; if (host_gnt !== 1'b1) begin miscompares++; $display("FAIL arb_gnt_after got=%b exp=1", host_gnt); end
    vectors++;
    if (mem_bus.adr !== 6'd5 || mem_bus.w !== 1'b1 || mem_bus.din !== 25'h1ABCDE) begin
      miscompares++; $display("FAIL arb_host_owner adr=%0d w=%b in=%h exp adr=5 w=1 in=1abcde", mem_bus.adr, mem_bus.w, mem_bus.din);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arb_go_in_host got=%b exp=0", busy); end
    host_req = 1'b0;
    tick();
    vectors++; if (host_gnt !== 1'b0) begin miscompares++; $display("FAIL arb_release got=%b exp=0", host_gnt); end
    vectors++; if (mem_bus.w !== 1'b0) begin miscompares++; $display("FAIL arb_release_mem_w got=%b exp=0", mem_bus.w); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arb_go_remembered got=%b exp=0", busy); end
    host_bus.w = 1'b0; perm_bus.r = 1'b0;
  endtask

  task automatic test_stale_done();
    int n, starts;
    model_en = 1'b0;
    armed = 1'b0;
    perm_done = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    vectors++; if (perm_start !== 1'b1) begin miscompares++; $display("FAIL stale_start got=%b exp=1", perm_start); end
    tick();
    tick();
    perm_done = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stale_busy got=%b exp=1", busy); end
    vectors++; if (round !== 5'd0) begin miscompares++; $display("FAIL stale_round got=%0d exp=0", round); end
    starts = 0; n = 0;
    while (busy && n < 20) begin
      if (perm_start) starts++;
      tick();
      n++;
    end
    vectors++; if (starts != 0) begin miscompares++; $display("FAIL stale_advance got=%0d exp=0", starts); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stale_no_timeout got=%b exp=0", busy); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stale_err got=%b exp=1", err); end
  endtask

  task automatic test_watchdog();
    int n, run_cycles, fins;
    model_en = 1'b0;
    perm_done = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wd_err_cleared got=%b exp=0", err); end
    run_cycles = 0; fins = 0; n = 0;
    tick();
    while (busy && n < 40) begin
      run_cycles++;
      if (finished) fins++;
      tick();
      n++;
    end
    if (finished) fins++;
    vectors++; if (run_cycles != 8) begin miscompares++; $display("FAIL wd_run_cycles got=%0d exp=8", run_cycles); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wd_err got=%b exp=1", err); end
    vectors++; if (fins != 0) begin miscompares++; $display("FAIL wd_finished got=%0d exp=0", fins); end
    vectors++; if (round !== 5'd0) begin miscompares++; $display("FAIL wd_round got=%0d exp=0", round); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    model_en = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_err_cleared got=%b exp=0", err); end
    n = 0;
    while (round !== 5'd1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if (round !== 5'd1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_reach_round1 round=%0d busy=%b exp round=1 busy=1", round, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (round !== 5'd0) begin miscompares++; $display("FAIL mid_round got=%0d exp=0", round); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got=%b exp=0", busy); end
    vectors++; if (perm_start !== 1'b0) begin miscompares++; $display("FAIL mid_perm_start got=%b exp=0", perm_start); end
    model_en = 1'b0;
    armed = 1'b0;
    perm_done = 1'b0;
    @(negedge clock) reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || round !== 5'd0) begin
      miscompares++; $display("FAIL mid_after_release busy=%b round=%0d exp busy=0 round=0", busy, round);
    end
  endtask

  initial begin
    host_bus.adr = '0; host_bus.din = '0; host_bus.r = 1'b0; host_bus.w = 1'b0;
    perm_bus.adr = '0; perm_bus.din = '0; perm_bus.r = 1'b0; perm_bus.w = 1'b0;
    test_reset();
    test_full_run();
    test_arbitration();
    test_stale_done();
    test_watchdog();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
